// File: rtl/vector_alu_seq_if.sv
// Request/response bundle for the sequential vector ALU.
// Master drives the operation request; slave returns busy/done, results and flags.
// No flow control beyond start/busy: a start seen while busy is dropped.
interface vector_alu_seq_if #(
    parameter int LANES = 5,
    parameter int WIDTH = 32
);
    logic                     start;
    logic                     vmode;
    logic [2:0]               ALUOp;
    logic [WIDTH-1:0]         imm32;
    logic [LANES*WIDTH-1:0]   va;
    logic [LANES*WIDTH-1:0]   vb;
    logic                     busy;
    logic                     done;
    logic [LANES*WIDTH-1:0]   result;
    logic [3:0]               ALUFlags;

    modport master (
        output start, vmode, ALUOp, imm32, va, vb,
        input  busy, done, result, ALUFlags
    );

    modport slave (
        input  start, vmode, ALUOp, imm32, va, vb,
        output busy, done, result, ALUFlags
    );
endinterface

// File: rtl/vector_alu_seq.sv
// Vector ALU: one shared scalar datapath walks LANES elements, one lane per cycle.
// Latency LANES cycles from accepting edge to done; one op per LANES+1 cycles back-to-back.
// No queuing: start is only honoured in IDLE/DONE, ignored while busy.
module vector_alu_seq #(
    parameter int LANES = 5,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    vector_alu_seq_if.slave   bus
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VW    = LANES * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VW-1:0]      va_q, va_d, vb_q, vb_d;
    logic [VW-1:0]      buf_q, buf_d, result_q, result_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic               vmode_q, vmode_d;
    logic [2:0]         op_q, op_d;
    logic               acc_n_q, acc_n_d, acc_z_q, acc_z_d;
    logic               acc_c_q, acc_c_d, acc_v_q, acc_v_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH-1:0]   lane_a, lane_b, lane_res;
    logic [WIDTH:0]     sum, diff;
    logic               lane_n, lane_z, lane_c, lane_v;

    // Shared scalar datapath for the lane selected by idx_q.
    always_comb begin
        lane_a   = va_q[idx_q*WIDTH +: WIDTH];
        lane_b   = vmode_q ? vb_q[idx_q*WIDTH +: WIDTH] : imm_q;
        sum      = {1'b0, lane_a} + {1'b0, lane_b};
        diff     = {1'b0, lane_a} - {1'b0, lane_b};
        lane_res = '0;
        lane_c   = 1'b0;
        lane_v   = 1'b0;
        case (op_q)
            3'b000: begin
                lane_res = sum[WIDTH-1:0];
                lane_c   = sum[WIDTH];
                lane_v   = (lane_a[WIDTH-1] == lane_b[WIDTH-1]) &&
                           (lane_res[WIDTH-1] != lane_a[WIDTH-1]);
            end
            3'b001: begin
                lane_res = diff[WIDTH-1:0];
                lane_c   = ~diff[WIDTH];   // carry means "no borrow"
                lane_v   = (lane_a[WIDTH-1] != lane_b[WIDTH-1]) &&
                           (lane_res[WIDTH-1] != lane_a[WIDTH-1]);
            end
            3'b010:  lane_res = lane_a & lane_b;
            3'b011:  lane_res = lane_a | lane_b;
            3'b100:  lane_res = lane_a ^ lane_b;
            3'b101:  lane_res = {{(WIDTH-1){1'b0}}, ($signed(lane_a) < $signed(lane_b))};
            3'b110:  lane_res = {{(WIDTH-1){1'b0}}, (lane_a < lane_b)};
            default: lane_res = lane_a;
        endcase
        lane_n = lane_res[WIDTH-1];
        lane_z = (lane_res == '0);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        va_d     = va_q;
        vb_d     = vb_q;
        imm_d    = imm_q;
        vmode_d  = vmode_q;
        op_d     = op_q;
        buf_d    = buf_q;
        result_d = result_q;
        flags_d  = flags_q;
        acc_n_d  = acc_n_q;
        acc_z_d  = acc_z_q;
        acc_c_d  = acc_c_q;
        acc_v_d  = acc_v_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    va_d    = bus.va;
                    vb_d    = bus.vb;
                    imm_d   = bus.imm32;
                    vmode_d = bus.vmode;
                    op_d    = bus.ALUOp;
                    idx_d   = '0;
                    acc_n_d = 1'b0;
                    acc_z_d = 1'b1;
                    acc_c_d = 1'b0;
                    acc_v_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                buf_d[idx_q*WIDTH +: WIDTH] = lane_res;
                acc_n_d = acc_n_q | lane_n;
                acc_z_d = acc_z_q & lane_z;
                acc_c_d = acc_c_q | lane_c;
                acc_v_d = acc_v_q | lane_v;
                if (idx_q == IDX_W'(LANES-1)) begin
                    // Commit includes the lane being written this cycle.
                    result_d = buf_d;
                    flags_d  = {acc_n_d, acc_z_d, acc_c_d, acc_v_d};
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            imm_q    <= '0;
            vmode_q  <= 1'b0;
            op_q     <= 3'b000;
            buf_q    <= '0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            acc_n_q  <= 1'b0;
            acc_z_q  <= 1'b0;
            acc_c_q  <= 1'b0;
            acc_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            imm_q    <= imm_d;
            vmode_q  <= vmode_d;
            op_q     <= op_d;
            buf_q    <= buf_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            acc_n_q  <= acc_n_d;
            acc_z_q  <= acc_z_d;
            acc_c_q  <= acc_c_d;
            acc_v_q  <= acc_v_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed bench for vector_alu_seq: LANES=5/WIDTH=32 main instance plus a LANES=1/WIDTH=8 corner instance.
module tb_vector_alu_seq;
    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    vector_alu_seq_if #(.LANES(5), .WIDTH(32)) bus  ();
    vector_alu_seq_if #(.LANES(1), .WIDTH(8))  bus1 ();

    vector_alu_seq #(.LANES(5), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    vector_alu_seq #(.LANES(1), .WIDTH(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] pk(input logic [31:0] l4, input logic [31:0] l3,
                                        input logic [31:0] l2, input logic [31:0] l1,
                                        input logic [31:0] l0);
        return {l4, l3, l2, l1, l0};
    endfunction

    // Called at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic do_op(input string tag, input logic vm, input logic [2:0] op,
                         input logic [31:0] imm, input logic [159:0] a, input logic [159:0] b,
                         input logic [159:0] exp_res, input logic [3:0] exp_fl);
        int bc;
        int guard;
        bus.vmode = vm;
        bus.ALUOp = op;
        bus.imm32 = imm;
        bus.va    = a;
        bus.vb    = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bc    = 0;
        guard = 0;
        while (bus.busy && guard < 50) begin
            bc++;
            guard++;
            @(negedge clk);
        end
        chk({tag, "_busy"},  bc, 5);
        chk({tag, "_done"},  bus.done, 1'b1);
        chk({tag, "_res"},   bus.result, exp_res);
        chk({tag, "_flags"}, bus.ALUFlags, exp_fl);
        @(negedge clk);
        chk({tag, "_done_off"}, bus.done, 1'b0);
    endtask

    initial begin
        int dn;
        int t;
        int rise_a;
        int rise_b;
        int first_done;
        logic prev_busy;
        logic [159:0] cap_res;
        logic [3:0]   cap_fl;

        reset = 1'b0;
        bus.start = 1'b0; bus.vmode = 1'b0; bus.ALUOp = 3'b000;
        bus.imm32 = '0;   bus.va = '0;      bus.vb = '0;
        bus1.start = 1'b0; bus1.vmode = 1'b0; bus1.ALUOp = 3'b000;
        bus1.imm32 = '0;   bus1.va = '0;      bus1.vb = '0;
        repeat (2) @(negedge clk);
        chk("rst_res",   bus.result, '0);
        chk("rst_flags", bus.ALUFlags, 4'b0000);
        chk("rst_busy",  bus.busy, 1'b0);
        chk("rst_done",  bus.done, 1'b0);
        chk("rst_l1_res", bus1.result, '0);

        reset = 1'b1;
        @(negedge clk);

        do_op("add",  1'b0, 3'b000, 32'd1, pk(4, 3, 2, 1, 0), '0, pk(5, 4, 3, 2, 1), 4'b0000);
        do_op("subz", 1'b1, 3'b001, 32'd0, pk(5, 5, 5, 5, 5), pk(5, 5, 5, 5, 5), '0, 4'b0110);
        do_op("addv", 1'b0, 3'b000, 32'd1, pk(0, 0, 32'h7FFFFFFF, 0, 0), '0,
              pk(1, 1, 32'h80000000, 1, 1), 4'b1001);
        do_op("subb", 1'b0, 3'b001, 32'd1, '0, '0, {5{32'hFFFFFFFF}}, 4'b1000);
        do_op("slt",  1'b0, 3'b101, 32'd0, {5{32'hFFFFFFFF}}, '0, pk(1, 1, 1, 1, 1), 4'b0000);
        do_op("sltu", 1'b0, 3'b110, 32'd0, {5{32'hFFFFFFFF}}, '0, '0, 4'b0100);
        do_op("and",  1'b1, 3'b010, 32'd0, {5{32'hFFFF0000}}, {5{32'h0F0F0F0F}},
              {5{32'h0F0F0000}}, 4'b0000);
        do_op("pass", 1'b1, 3'b111, 32'h1234, pk(32'h80000000, 0, 0, 0, 0), {5{32'hFFFFFFFF}},
              pk(32'h80000000, 0, 0, 0, 0), 4'b1000);
        do_op("or",   1'b0, 3'b011, 32'h100, pk(0, 1, 2, 3, 4), '0,
              pk(32'h100, 32'h101, 32'h102, 32'h103, 32'h104), 4'b0000);

        // Inputs changed and start re-pulsed while running must not matter.
        bus.vmode = 1'b0; bus.ALUOp = 3'b100; bus.imm32 = 32'hFF;
        bus.va = pk(5, 4, 3, 2, 1); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_no_partial", bus.result, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'h104));
        @(negedge clk);
        bus.va = '0; bus.ALUOp = 3'b000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dn = 0; cap_res = '0; cap_fl = '0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                dn++;
                cap_res = bus.result;
                cap_fl  = bus.ALUFlags;
            end
            @(negedge clk);
        end
        chk("mid_done_cnt", dn, 1);
        chk("mid_res", cap_res, pk(32'hFA, 32'hFB, 32'hFC, 32'hFD, 32'hFE));
        chk("mid_flags", cap_fl, 4'b0000);

        // start held high: restart straight out of DONE.
        bus.vmode = 1'b0; bus.ALUOp = 3'b000; bus.imm32 = 32'd0;
        bus.va = pk(9, 8, 7, 6, 5); bus.start = 1'b1;
        rise_a = -1; rise_b = -1; first_done = -1; dn = 0; prev_busy = 1'b0;
        for (t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (bus.busy && !prev_busy) begin
                if (rise_a < 0) rise_a = t;
                else if (rise_b < 0) begin
                    rise_b = t;
                    bus.start = 1'b0;
                end
            end
            if (bus.done) begin
                dn++;
                if (first_done < 0) first_done = t;
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        chk("held_first_busy", rise_a, 1);
        chk("held_first_done", first_done, 6);
        chk("held_gap", rise_b - rise_a, 6);
        chk("held_after_done", rise_b - first_done, 1);
        chk("held_done_cnt", dn, 2);
        chk("held_res", bus.result, pk(9, 8, 7, 6, 5));

        // Reset while lane 3 is being processed.
        bus.imm32 = 32'd1; bus.va = pk(1, 1, 1, 1, 1); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_res",   bus.result, '0);
        chk("abort_flags", bus.ALUFlags, 4'b0000);
        chk("abort_busy",  bus.busy, 1'b0);
        chk("abort_done",  bus.done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        chk("abort_no_done", dn, 0);

        // Single-lane, 8-bit instance: RUN for one cycle, then DONE.
        bus1.vmode = 1'b0; bus1.ALUOp = 3'b000; bus1.imm32 = 8'h01;
        bus1.va = 8'hFF; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        chk("l1_busy", bus1.busy, 1'b1);
        @(negedge clk);
        chk("l1_done",  bus1.done, 1'b1);
        chk("l1_res",   bus1.result, 8'h00);
        chk("l1_flags", bus1.ALUFlags, 4'b0110);
        @(negedge clk);
        chk("l1_idle", {bus1.busy, bus1.done}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
